iu_regfile_rd: RTL and testbench



---
 rtl/iu_regfile_pkg.sv | 35 +++
 rtl/iu_regfile_rd.sv | 135 +++++++++++++
 tb/tb_iu_regfile_rd.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/iu_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iu_regfile_pkg
// Brief    : Shared read/commit record types for the integer register file.
// Revision : 1.0  initial release
// ============================================================================
package iu_regfile_pkg;

    localparam int NREGADDRMSB = 7;

    typedef struct packed {
        logic [NREGADDRMSB:0] op1_addr;
        logic [NREGADDRMSB:0] op2_addr;
    } regfile_read_in_type;

    typedef struct packed {
        logic [31:0] op1_data;
        logic [6:0]  op1_parity;
        logic [31:0] op2_data;
        logic [6:0]  op2_parity;
    } regfile_read_out_type;

    typedef struct packed {
        logic [NREGADDRMSB:0] ph1_addr;
        logic [31:0]          ph1_data;
        logic [6:0]           ph1_parity;
        logic                 ph1_we;
        logic [NREGADDRMSB:0] ph2_addr;
        logic [31:0]          ph2_data;
        logic [6:0]           ph2_parity;
        logic                 ph2_we;
    } regfile_commit_type;

endpackage
`default_nettype wire

// File: rtl/iu_regfile_rd.sv
`default_nettype none
// ============================================================================
// Module   : iu_regfile_rd
// Brief    : Integer register file: two commit writes, two registered reads,
//            partial-parity checking with SEU reporting, zero-init after reset.
//            Optional same-cycle write-to-read forwarding: IU_RF_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
module iu_regfile_rd
    import iu_regfile_pkg::*;
#(
    parameter int ADDRW   = NREGADDRMSB + 1,
    parameter int ERRCNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  regfile_read_in_type  rin,
    output regfile_read_out_type rout,
    input  regfile_commit_type   cin,
    output logic                 init_done,
    output logic                 err_valid,
    output logic [1:0]           err_port,
    output logic [ADDRW-1:0]     err_addr,
    output logic [ERRCNTW-1:0]   err_cnt
);

    localparam int c_depth = 1 << ADDRW;

    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    // Entry layout: {parity[6:0], data[31:0]}
    logic [38:0]      r_mem [c_depth];
    logic [0:0]       r_state;
    logic [ADDRW-1:0] r_init_cnt;

    logic             w_run;
    logic [ADDRW-1:0] w_a1;
    logic [ADDRW-1:0] w_a2;
    logic [ADDRW-1:0] w_wa1;
    logic [ADDRW-1:0] w_wa2;
    logic [38:0]      w_rd1;
    logic [38:0]      w_rd2;
    logic             w_e1;
    logic             w_e2;

    function automatic logic [6:0] f_par(input logic [31:0] d);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            p[i % 7] = p[i % 7] ^ d[i];
        end
        return p;
    endfunction

    assign w_run = (r_state == c_st_run);
    assign w_a1  = rin.op1_addr[ADDRW-1:0];
    assign w_a2  = rin.op2_addr[ADDRW-1:0];
    assign w_wa1 = cin.ph1_addr[ADDRW-1:0];
    assign w_wa2 = cin.ph2_addr[ADDRW-1:0];

    always_comb begin
        w_rd1 = r_mem[w_a1];
        w_rd2 = r_mem[w_a2];
`ifdef IU_RF_BYPASS_EN
        // ph2 is younger in program order, so it takes precedence over ph1.
        if (cin.ph2_we && (w_wa2 == w_a1)) begin
            w_rd1 = {cin.ph2_parity, cin.ph2_data};
        end else if (cin.ph1_we && (w_wa1 == w_a1)) begin
            w_rd1 = {cin.ph1_parity, cin.ph1_data};
        end
        if (cin.ph2_we && (w_wa2 == w_a2)) begin
            w_rd2 = {cin.ph2_parity, cin.ph2_data};
        end else if (cin.ph1_we && (w_wa1 == w_a2)) begin
            w_rd2 = {cin.ph1_parity, cin.ph1_data};
        end
`endif
    end

    assign w_e1 = (f_par(w_rd1[31:0]) != w_rd1[38:32]);
    assign w_e2 = (f_par(w_rd2[31:0]) != w_rd2[38:32]);

    // Array has no reset; INIT overwrites every entry before RUN.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_init_cnt] <= '0;
        end else begin
            if (cin.ph1_we) begin
                r_mem[w_wa1] <= {cin.ph1_parity, cin.ph1_data};
            end
            if (cin.ph2_we) begin
                r_mem[w_wa2] <= {cin.ph2_parity, cin.ph2_data};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_init;
            r_init_cnt <= '0;
            init_done  <= 1'b0;
            rout       <= '0;
            err_valid  <= 1'b0;
            err_port   <= 2'b00;
            err_addr   <= '0;
            err_cnt    <= '0;
        end else begin
            init_done <= w_run;
            if (!w_run) begin
                if (r_init_cnt == {ADDRW{1'b1}}) begin
                    r_state <= c_st_run;
                end else begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                end
                rout      <= '0;
                err_valid <= 1'b0;
                err_port  <= 2'b00;
                err_addr  <= '0;
            end else begin
                rout.op1_data   <= w_rd1[31:0];
                rout.op1_parity <= w_rd1[38:32];
                rout.op2_data   <= w_rd2[31:0];
                rout.op2_parity <= w_rd2[38:32];
                err_valid       <= w_e1 | w_e2;
                err_port        <= {w_e2, w_e1};
                err_addr        <= w_e1 ? w_a1 : (w_e2 ? w_a2 : '0);
                if ((w_e1 || w_e2) && (err_cnt != {ERRCNTW{1'b1}})) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iu_regfile_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_iu_regfile_rd
// Brief    : Self-checking bench for iu_regfile_rd (directed table + random).
// Revision : 1.0  initial release
// ============================================================================
module tb_iu_regfile_rd;
    import iu_regfile_pkg::*;

    localparam int ADDRW = NREGADDRMSB + 1;
    localparam int DEPTH = 1 << ADDRW;
`ifdef IU_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    regfile_read_in_type  rin;
    regfile_read_out_type rout;
    regfile_commit_type   cin;
    logic                 init_done;
    logic                 err_valid;
    logic [1:0]           err_port;
    logic [ADDRW-1:0]     err_addr;
    logic [15:0]          err_cnt;

    iu_regfile_rd dut (
        .clk       (clk),
        .rst       (rst),
        .rin       (rin),
        .rout      (rout),
        .cin       (cin),
        .init_done (init_done),
        .err_valid (err_valid),
        .err_port  (err_port),
        .err_addr  (err_addr),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain arrays of stored words plus a saturating counter.
    logic [31:0] md [DEPTH];
    logic [6:0]  mp [DEPTH];
    int          mcnt;

    function automatic logic [6:0] par7(input logic [31:0] d);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 7; i++)
            for (int j = i; j < 32; j += 7)
                p[i] = p[i] ^ d[j];
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void mreset();
        for (int i = 0; i < DEPTH; i++) begin
            md[i] = '0;
            mp[i] = '0;
        end
        mcnt = 0;
    endfunction

    function automatic void mread(input logic [ADDRW-1:0] a, output logic [31:0] d, output logic [6:0] p);
        d = md[a];
        p = mp[a];
        if (BYP) begin
            if (cin.ph2_we && cin.ph2_addr == a) begin
                d = cin.ph2_data; p = cin.ph2_parity;
            end else if (cin.ph1_we && cin.ph1_addr == a) begin
                d = cin.ph1_data; p = cin.ph1_parity;
            end
        end
    endfunction

    // One RUN-mode cycle: predict, advance the model, clock, optionally compare.
    task automatic run_cycle(input string nm, input bit check);
        logic [31:0] d1, d2;
        logic [6:0]  p1, p2;
        logic        e1, e2;
        logic [ADDRW-1:0] ea;
        mread(rin.op1_addr, d1, p1);
        mread(rin.op2_addr, d2, p2);
        e1 = (par7(d1) != p1);
        e2 = (par7(d2) != p2);
        ea = e1 ? rin.op1_addr : rin.op2_addr;
        if ((e1 || e2) && mcnt < 65535) mcnt++;
        if (cin.ph1_we) begin md[cin.ph1_addr] = cin.ph1_data; mp[cin.ph1_addr] = cin.ph1_parity; end
        if (cin.ph2_we) begin md[cin.ph2_addr] = cin.ph2_data; mp[cin.ph2_addr] = cin.ph2_parity; end
        tick();
        if (check) begin
            chk({nm, ".op1"}, {rout.op1_parity, rout.op1_data}, {p1, d1});
            chk({nm, ".op2"}, {rout.op2_parity, rout.op2_data}, {p2, d2});
            chk({nm, ".err"}, {err_valid, err_port}, {e1 | e2, e2, e1});
            if (e1 || e2) chk({nm, ".err_addr"}, err_addr, ea);
            chk({nm, ".err_cnt"}, err_cnt, mcnt);
        end
    endtask

    // Post-reset init walk; commits during INIT must be ignored.
    task automatic do_init();
        for (int k = 1; k <= DEPTH + 1; k++) begin
            rin = '0;
            cin = '0;
            if (k <= DEPTH) begin
                cin.ph1_we = 1'b1; cin.ph1_addr = 8'd7; cin.ph1_data = 32'hFFFF_FFFF; cin.ph1_parity = 7'h55;
            end
            tick();
            chk("init_done", init_done, (k == DEPTH + 1));
            if (k == DEPTH) chk("init_rout", rout, '0);
            if (k == DEPTH) chk("init_err_valid", err_valid, 1'b0);
        end
        cin = '0;
        mreset();
    endtask

    typedef struct {
        logic w1; logic [7:0] a1w; logic [31:0] d1w; logic [6:0] p1w;
        logic w2; logic [7:0] a2w; logic [31:0] d2w; logic [6:0] p2w;
        logic [7:0] ra1; logic [7:0] ra2;
        logic [31:0] e1; logic [31:0] e2;
        logic ev; logic [1:0] ep; logic [7:0] ea; logic [15:0] ecnt;
    } vec_t;

    vec_t vt [11];

    initial begin
        vt[0]  = '{1, 5, 32'hDEADBEEF, par7(32'hDEADBEEF), 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2'b00, 0, 0};
        vt[2]  = '{1, 9, 32'h11111111, par7(32'h11111111), 1, 9, 32'h22222222, par7(32'h22222222),
                   5, 0, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h22222222, 32'h22222222, 0, 2'b00, 0, 0};
        vt[4]  = '{1, 12, 32'hCAFEF00D, par7(32'hCAFEF00D), 0, 0, 0, 0,
                   12, 9, BYP ? 32'hCAFEF00D : 32'h0, 32'h22222222, 0, 2'b00, 0, 0};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 32'hCAFEF00D, 32'hCAFEF00D, 0, 2'b00, 0, 0};
        vt[6]  = '{1, 3, 32'h1, 7'h00, 1, 4, 32'h2, 7'h7F, 0, 0, 0, 0, 0, 2'b00, 0, 0};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 32'h1, 32'h2, 1, 2'b11, 3, 1};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 5, 32'h2, 32'hDEADBEEF, 1, 2'b01, 4, 2};
        vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 4, 32'hDEADBEEF, 32'h2, 1, 2'b10, 4, 3};
        vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3};

        rin = '0;
        cin = '0;
        #1;
        chk("reset_rout", rout, '0);
        chk("reset_flags", {init_done, err_valid, err_port, err_addr, err_cnt}, '0);
        repeat (3) tick();
        #2 rst = 1'b0;
        do_init();

        for (int i = 0; i < 11; i++) begin
            cin = '0;
            cin.ph1_we = vt[i].w1; cin.ph1_addr = vt[i].a1w; cin.ph1_data = vt[i].d1w; cin.ph1_parity = vt[i].p1w;
            cin.ph2_we = vt[i].w2; cin.ph2_addr = vt[i].a2w; cin.ph2_data = vt[i].d2w; cin.ph2_parity = vt[i].p2w;
            rin.op1_addr = vt[i].ra1;
            rin.op2_addr = vt[i].ra2;
            run_cycle($sformatf("vec%0d", i), 1'b0);
            chk($sformatf("vec%0d.data", i), {rout.op1_data, rout.op2_data}, {vt[i].e1, vt[i].e2});
            chk($sformatf("vec%0d.err", i), {err_valid, err_port, err_cnt}, {vt[i].ev, vt[i].ep, vt[i].ecnt});
            if (vt[i].ev) chk($sformatf("vec%0d.err_addr", i), err_addr, vt[i].ea);
        end

        for (int n = 0; n < 500; n++) begin
            cin.ph1_we     = 1'($urandom_range(0, 1));
            cin.ph1_addr   = 8'($urandom_range(0, 15));
            cin.ph1_data   = $urandom;
            cin.ph1_parity = ($urandom_range(0, 9) == 0) ? 7'($urandom) : par7(cin.ph1_data);
            cin.ph2_we     = 1'($urandom_range(0, 1));
            cin.ph2_addr   = 8'($urandom_range(0, 15));
            cin.ph2_data   = $urandom;
            cin.ph2_parity = ($urandom_range(0, 9) == 0) ? 7'($urandom) : par7(cin.ph2_data);
            rin.op1_addr   = 8'($urandom_range(0, 15));
            rin.op2_addr   = 8'($urandom_range(0, 15));
            run_cycle("rand", 1'b1);
        end

        // Plant a bad word and read it until the counter saturates.
        cin = '0;
        cin.ph1_we = 1'b1; cin.ph1_addr = 8'd40; cin.ph1_data = 32'h5; cin.ph1_parity = 7'h00;
        rin = '0;
        run_cycle("sat_wr", 1'b1);
        cin = '0;
        rin.op1_addr = 8'd40;
        rin.op2_addr = 8'd40;
        for (int n = 0; n < 65539; n++) run_cycle("sat", 1'b0);
        chk("sat_cnt", err_cnt, 16'hFFFF);
        chk("sat_err", {err_valid, err_port, err_addr}, {1'b1, 2'b11, 8'd40});
        run_cycle("sat_hold", 1'b1);

        // Asynchronous reset mid-run, then again mid-init.
        #1 rst = 1'b1;
        #1;
        chk("midrun_rst_rout", rout, '0);
        chk("midrun_rst_flags", {init_done, err_valid, err_port, err_addr, err_cnt}, '0);
        tick();
        #2 rst = 1'b0;
        repeat (50) tick();
        chk("midinit_done", init_done, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("midinit_rst_flags", {init_done, err_valid, err_cnt}, '0);
        tick();
        #2 rst = 1'b0;
        do_init();
        rin.op1_addr = 8'd40;
        rin.op2_addr = 8'd5;
        run_cycle("post_reinit", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
